// File: rtl/mat_vec_engine.sv
// Matrix-vector multiply engine: one column per cycle, SIZE parallel MACs.
// Define MAT_VEC_SIGNED_EN for two's-complement operands and results.
module mat_vec_engine #(
  parameter int SIZE   = 2,
  parameter int DATA_W = 8,
  parameter int OUT_W  = 2*DATA_W + $clog2(SIZE)
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  start,
  input  logic                                  accum,
  input  logic [SIZE-1:0][SIZE-1:0][DATA_W-1:0] mtx_in,
  input  logic [SIZE-1:0][DATA_W-1:0]           vec_in,
  output logic [SIZE-1:0][OUT_W-1:0]            vec_out,
  output logic                                  busy,
  output logic                                  done
);

  localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int PW = 2*DATA_W;
  localparam logic [CW-1:0] LAST = CW'(SIZE-1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                                state_q, state_d;
  logic [CW-1:0]                         col_q, col_d;
  logic [SIZE-1:0][SIZE-1:0][DATA_W-1:0] mtx_q, mtx_d;
  logic [SIZE-1:0][DATA_W-1:0]           vec_q, vec_d;
  logic [SIZE-1:0][OUT_W-1:0]            acc_q, acc_d;
  logic [SIZE-1:0][OUT_W-1:0]            prod;

  for (genvar g = 0; g < SIZE; g++) begin : g_mul
`ifdef MAT_VEC_SIGNED_EN
    logic signed [PW-1:0] p;
    assign p = PW'($signed(mtx_q[g][col_q]))
             * PW'($signed(vec_q[col_q]));
`else
    logic [PW-1:0] p;
    assign p = {{DATA_W{1'b0}}, mtx_q[g][col_q]}
             * {{DATA_W{1'b0}}, vec_q[col_q]};
`endif
    // size cast sign- or zero-extends following p's signedness
    assign prod[g] = OUT_W'(p);
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    mtx_d   = mtx_q;
    vec_d   = vec_q;
    acc_d   = acc_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          col_d   = '0;
          mtx_d   = mtx_in;
          vec_d   = vec_in;
          acc_d   = accum ? acc_q : '0;
        end
      end
      RUN: begin
        for (int i = 0; i < SIZE; i++) begin
          acc_d[i] = acc_q[i] + prod[i];
        end
        col_d = col_q + 1'b1;
        if (col_q == LAST) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      col_q   <= '0;
      mtx_q   <= '0;
      vec_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      mtx_q   <= mtx_d;
      vec_q   <= vec_d;
      acc_q   <= acc_d;
    end
  end

  assign vec_out = acc_q;
  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);

endmodule

// File: tb/tb_mat_vec_engine.sv
// Bench for mat_vec_engine: vector table, corner sequences, random ops.
// Honors MAT_VEC_SIGNED_EN for expected values.
module tb_mat_vec_engine;

  localparam int S  = 2;
  localparam int DW = 8;
  localparam int OW = 2*DW + $clog2(S);
  localparam int S4 = 4;
  localparam int OW4 = 2*DW + $clog2(S4);

  typedef logic [S-1:0][S-1:0][DW-1:0] mtx_t;
  typedef logic [S-1:0][DW-1:0]        vin_t;
  typedef logic [S-1:0][OW-1:0]        vout_t;

  typedef struct {
    mtx_t  m;
    vin_t  v;
    logic  acc;
    vout_t exp;
  } rec_t;

  logic  clk = 1'b0;
  logic  reset_n;
  logic  start, accum;
  mtx_t  mtx_in;
  vin_t  vec_in;
  vout_t vec_out;
  logic  busy, done;

  logic                            start4;
  logic [S4-1:0][S4-1:0][DW-1:0]   mtx4;
  logic [S4-1:0][DW-1:0]           vec4;
  logic [S4-1:0][OW4-1:0]          out4;
  logic                            busy4, done4;

  int nvec  = 0;
  int nfail = 0;

  mat_vec_engine #(.SIZE(S), .DATA_W(DW)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .accum(accum),
    .mtx_in(mtx_in), .vec_in(vec_in), .vec_out(vec_out),
    .busy(busy), .done(done)
  );

  mat_vec_engine #(.SIZE(S4), .DATA_W(DW)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .start(start4), .accum(1'b0),
    .mtx_in(mtx4), .vec_in(vec4), .vec_out(out4),
    .busy(busy4), .done(done4)
  );

  always #5 clk = ~clk;

  task automatic step(int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  function automatic mtx_t mk(int a, int b, int c, int d);
    mtx_t t;
    t[0][0] = DW'(a); t[0][1] = DW'(b);
    t[1][0] = DW'(c); t[1][1] = DW'(d);
    return t;
  endfunction

  function automatic vin_t vv(int a, int b);
    vin_t t;
    t[0] = DW'(a); t[1] = DW'(b);
    return t;
  endfunction

  function automatic vout_t ov(longint a, longint b);
    vout_t t;
    t[0] = OW'(a); t[1] = OW'(b);
    return t;
  endfunction

  function automatic longint val(logic [DW-1:0] x);
`ifdef MAT_VEC_SIGNED_EN
    return longint'($signed(x));
`else
    return longint'(x);
`endif
  endfunction

  // Reference: plain dot products, modulo 2^OW
  function automatic vout_t model(mtx_t m, vin_t v, logic acc, vout_t prev);
    vout_t  r;
    longint s;
    for (int i = 0; i < S; i++) begin
      s = acc ? longint'(prev[i]) : 64'sd0;
      for (int c = 0; c < S; c++) s += val(m[i][c]) * val(v[c]);
      r[i] = OW'(s);
    end
    return r;
  endfunction

  task automatic run_op(string tag, mtx_t m, vin_t v, logic acc, vout_t exp);
    mtx_in = m; vec_in = v; accum = acc; start = 1'b1;
    step();
    start = 1'b0;
    mtx_in = '0; vec_in = '0; accum = 1'b0;
    chk({tag, ".busy_k"}, 64'(busy), 64'd1);
    chk({tag, ".done_k"}, 64'(done), 64'd0);
    step(S - 1);
    chk({tag, ".done_pre"}, 64'(done), 64'd0);
    step();
    chk({tag, ".done"}, 64'(done), 64'd1);
    chk({tag, ".busy"}, 64'(busy), 64'd0);
    chk({tag, ".vec_out"}, 64'(vec_out), 64'(exp));
  endtask

  rec_t  tbl[4];
  vout_t prev;
  vout_t e;
  mtx_t  rm;
  vin_t  rv;
  logic  ra;

  initial begin
    tbl[0] = '{mk(1, 2, 3, 4), vv(1, 2), 1'b0, ov(5, 11)};
    tbl[1] = '{mk(5, 6, 7, 8), vv(3, 4), 1'b0, ov(39, 53)};
    tbl[2] = '{mk(1, 0, 0, 1), vv(1, 1), 1'b1, ov(40, 54)};
`ifdef MAT_VEC_SIGNED_EN
    tbl[3] = '{mk(-1, 2, 3, -4), vv(1, 2), 1'b0, ov(3, -5)};
`else
    tbl[3] = '{mk(-1, 2, 3, -4), vv(1, 2), 1'b0, ov(259, 507)};
`endif

    reset_n = 1'b0; start = 1'b0; accum = 1'b0;
    mtx_in = '0; vec_in = '0;
    start4 = 1'b0; mtx4 = '0; vec4 = '0;
    step(2);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    chk("rst.vec_out", 64'(vec_out), 64'd0);
    reset_n = 1'b1;
    step();

    for (int i = 0; i < 4; i++) begin
      run_op($sformatf("tbl%0d", i), tbl[i].m, tbl[i].v, tbl[i].acc,
             tbl[i].exp);
    end
    prev = tbl[3].exp;

    step(5);
    chk("hold.done", 64'(done), 64'd1);
    chk("hold.vec_out", 64'(vec_out), 64'(prev));

    // start pulsed with new operands mid-RUN must be ignored
    mtx_in = mk(2, 3, 4, 5); vec_in = vv(6, 7); start = 1'b1;
    step();
    mtx_in = '0; vec_in = '0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("norestart.done", 64'(done), 64'd1);
    chk("norestart.vec_out", 64'(vec_out), 64'(ov(33, 59)));

    // reset during RUN
    mtx_in = mk(9, 9, 9, 9); vec_in = vv(9, 9); start = 1'b1;
    step();
    start = 1'b0;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("midrst.busy", 64'(busy), 64'd0);
    chk("midrst.done", 64'(done), 64'd0);
    chk("midrst.vec_out", 64'(vec_out), 64'd0);
    step(3);
    chk("midrst.idle", 64'(done), 64'd0);
    run_op("postrst", mk(1, 2, 3, 4), vv(2, 1), 1'b1, ov(4, 10));
    prev = ov(4, 10);

    // SIZE=4 all-ones-byte: 4*255*255 without wrap
    mtx4 = '1; vec4 = '1; start4 = 1'b1;
    step();
    start4 = 1'b0; mtx4 = '0; vec4 = '0;
    chk("s4.busy", 64'(busy4), 64'd1);
    step(S4 - 1);
    chk("s4.done_pre", 64'(done4), 64'd0);
    step();
    chk("s4.done", 64'(done4), 64'd1);
    for (int i = 0; i < S4; i++) begin
      chk($sformatf("s4.out%0d", i), 64'(out4[i]), 64'd260100);
    end

    // random back-to-back ops against the model
    for (int n = 0; n < 40; n++) begin
      for (int r = 0; r < S; r++) begin
        for (int c = 0; c < S; c++) rm[r][c] = DW'($urandom);
        rv[r] = DW'($urandom);
      end
      ra = 1'($urandom_range(0, 1));
      e = model(rm, rv, ra, prev);
      run_op($sformatf("rnd%0d", n), rm, rv, ra, e);
      prev = e;
      if ($urandom_range(0, 3) == 0) step($urandom_range(1, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
